// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for the serial subtractor: operands in, registered
// difference and borrow out.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Borrow;

    modport master (
        output start, A, B,
        input  busy, done, Diff, Borrow
    );

    modport slave (
        input  start, A, B,
        output busy, done, Diff, Borrow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle unsigned subtractor: BITS_PER_CYCLE bits per clock, LSB slice first,
// borrow rippled between slices; Diff/Borrow update only on completion.
module serial_subtractor #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input logic                clk,
    input logic                rst_n,
    serial_subtractor_if.slave bus
);
    localparam int NSLICE = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             borrow_out_q, borrow_out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [BITS_PER_CYCLE:0] slice_diff;
    logic [WIDTH-1:0]        res_shifted;

    // The top bit of the (k+1)-bit slice difference is set exactly when the slice went negative.
    always_comb begin
        slice_diff  = {1'b0, a_q[BITS_PER_CYCLE-1:0]}
                    - {1'b0, b_q[BITS_PER_CYCLE-1:0]}
                    - {{BITS_PER_CYCLE{1'b0}}, borrow_q};
        res_shifted = (res_q >> BITS_PER_CYCLE)
                    | (WIDTH'(slice_diff[BITS_PER_CYCLE-1:0]) << (WIDTH - BITS_PER_CYCLE));
    end

    always_comb begin
        // NOTE: every *_d gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        diff_d       = diff_q;
        borrow_d     = borrow_q;
        borrow_out_d = borrow_out_q;
        cnt_d        = cnt_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    a_d      = bus.A;
                    b_d      = bus.B;
                    res_d    = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d      = a_q >> BITS_PER_CYCLE;
                b_d      = b_q >> BITS_PER_CYCLE;
                res_d    = res_shifted;
                borrow_d = slice_diff[BITS_PER_CYCLE];
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_SLICE) begin
                    diff_d       = res_shifted;
                    borrow_out_d = slice_diff[BITS_PER_CYCLE];
                    done_d       = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
        if (!rst_n) begin
            // NOTE: plain registers only, so clearing them all in reset is cheap and aborts any run.
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            diff_q       <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            diff_q       <= diff_d;
            borrow_q     <= borrow_d;
            borrow_out_q <= borrow_out_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.Diff   = diff_q;
    assign bus.Borrow = borrow_out_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: an 8-bit/1-bit-per-cycle instance and a
// 4-bit/2-bit-per-cycle instance, each with its own expectation queue and monitor.
module tb_serial_subtractor;
    localparam int N8 = 8;
    localparam int N4 = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(4)) bus4 ();

    serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_subtractor #(.WIDTH(4), .BITS_PER_CYCLE(2)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    typedef struct {
        logic [7:0] diff;
        logic       borrow;
        int         acc;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Reference: plain modular difference and unsigned compare.
    function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input int acc);
        exp_t e;
        e.diff   = 8'(int'(a) - int'(b));
        e.borrow = (a < b);
        e.acc    = acc;
        return e;
    endfunction

    function automatic exp_t model4(input logic [3:0] a, input logic [3:0] b, input int acc);
        exp_t e;
        e.diff   = {4'd0, 4'(int'(a) - int'(b))};
        e.borrow = (a < b);
        e.acc    = acc;
        return e;
    endfunction

    // Monitors: expected busy/done/Diff/Borrow each cycle from the queue head and held result.
    logic [7:0] h8_diff, h4_diff;
    logic       h8_b, h4_b, e8_busy, e8_done, e4_busy, e4_done;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            q8.delete();
            h8_diff = '0; h8_b = 1'b0; e8_busy = 1'b0; e8_done = 1'b0;
        end else begin
            e8_done = (q8.size() > 0) && (cyc == q8[0].acc + N8);
            e8_busy = (q8.size() > 0) && !e8_done && (cyc >= q8[0].acc);
            if (e8_done) begin
                h8_diff = q8[0].diff;
                h8_b    = q8[0].borrow;
                void'(q8.pop_front());
            end
        end
        check("out8{busy,done,borrow,diff}",
              {21'd0, bus8.busy, bus8.done, bus8.Borrow, bus8.Diff},
              {21'd0, e8_busy, e8_done, h8_b, h8_diff});
    end

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            q4.delete();
            h4_diff = '0; h4_b = 1'b0; e4_busy = 1'b0; e4_done = 1'b0;
        end else begin
            e4_done = (q4.size() > 0) && (cyc == q4[0].acc + N4);
            e4_busy = (q4.size() > 0) && !e4_done && (cyc >= q4[0].acc);
            if (e4_done) begin
                h4_diff = q4[0].diff;
                h4_b    = q4[0].borrow;
                void'(q4.pop_front());
            end
        end
        check("out4{busy,done,borrow,diff}",
              {24'd0, bus4.busy, bus4.done, bus4.Borrow, 1'b0, bus4.Diff},
              {24'd0, e4_busy, e4_done, h4_b, 1'b0, h4_diff[3:0]});
    end

    // Drivers: wait (bounded) for a negedge with busy low, so the next edge accepts.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input bit hold);
        int waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus8.busy && waited < 40);
        check("issue8_wait_idle", {31'd0, bus8.busy}, 32'd0);
        bus8.start = 1'b1;
        bus8.A     = a;
        bus8.B     = b;
        q8.push_back(model8(a, b, cyc + 1));
        if (!hold) begin
            @(negedge clk);
            bus8.start = 1'b0;
            bus8.A     = 8'($urandom);
            bus8.B     = 8'($urandom);
        end
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input bit hold);
        int waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus4.busy && waited < 20);
        check("issue4_wait_idle", {31'd0, bus4.busy}, 32'd0);
        bus4.start = 1'b1;
        bus4.A     = a;
        bus4.B     = b;
        q4.push_back(model4(a, b, cyc + 1));
        if (!hold) begin
            @(negedge clk);
            bus4.start = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus8.start = 1'b0; bus8.A = '0; bus8.B = '0;
        bus4.start = 1'b0; bus4.A = '0; bus4.B = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed values, including the wrap and borrow corners.
        issue8(8'h05, 8'h03, 1'b0);
        issue8(8'h03, 8'h05, 1'b0);
        issue8(8'h00, 8'h00, 1'b0);
        issue8(8'h00, 8'hFF, 1'b0);
        issue8(8'hFF, 8'h00, 1'b0);
        issue8(8'h80, 8'h81, 1'b0);

        // Start pulsed mid-run is ignored.
        issue8(8'h40, 8'h10, 1'b0);
        repeat (2) @(negedge clk);
        bus8.start = 1'b1; bus8.A = 8'hFF; bus8.B = 8'h01;
        @(negedge clk);
        bus8.start = 1'b0;

        // Reset mid-run aborts with no done and clears the outputs.
        issue8(8'hC3, 8'h15, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Start held: back-to-back accepts from the DONE state.
        for (int i = 0; i < 10; i++) issue8(8'($urandom), 8'($urandom), i != 9);

        // Random operands with random idle gaps.
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue8(8'($urandom), 8'($urandom), 1'b0);
        end

        // Exhaustive 4-bit, two bits per cycle, start held throughout.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                issue4(4'(a), 4'(b), !(a == 15 && b == 15));

        repeat (20) @(negedge clk);
        check("drain_q8", q8.size(), 32'd0);
        check("drain_q4", q4.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
